// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and FSM encoding for the switch debouncer
package debounce_pkg;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  typedef enum logic {ST_STABLE = 1'b0, ST_COUNTING = 1'b1} state_t;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser, stability counter and accept FSM for one switch bit
module debounce_bit import debounce_pkg::*; #(
  parameter int CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db,
  output logic chg
);
  localparam int CW = $clog2(CYCLES);
  logic sync1, sync2, accept;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  // registers: synchroniser, FSM state, counter, accepted level and change flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_STABLE;
      cnt   <= '0;
      db    <= 1'b0;
      chg   <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      state <= state_n;
      cnt   <= cnt_n;
      chg   <= accept;
      if (accept) db <= sync2;
    end
  end
  // next state: any match or an acceptance returns to STABLE, a mismatch keeps/starts counting
  always_comb begin
    state_n = (sync2 == db || accept) ? ST_STABLE : ST_COUNTING;
  end
  // datapath: accept after CYCLES consecutive mismatching samples, else count or clear
  always_comb begin
    accept = state == ST_COUNTING && sync2 != db && cnt == CW'(CYCLES - 1);
    cnt_n  = (sync2 == db || accept) ? '0 : (state == ST_STABLE) ? CW'(1) : cnt + 1'b1;
  end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronise and debounce WIDTH switches; SW_EDGE_DETECT_EN adds sw_rise/sw_fall
module switch_debouncer import debounce_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic             sw_changed
`ifdef SW_EDGE_DETECT_EN
  ,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`endif
);
  logic [WIDTH-1:0] chg;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk (clk),
      .rst (rst),
      .sw  (sw[i]),
      .db  (sw_db[i]),
      .chg (chg[i])
    );
  end
  // per-bit change flags are registered, so the OR is glitch-free and aligned with sw_db
  assign sw_changed = |chg;
`ifdef SW_EDGE_DETECT_EN
  // a bit that just changed and now reads 1 rose; one that now reads 0 fell
  assign sw_rise = chg & sw_db;
  assign sw_fall = chg & ~sw_db;
`endif
endmodule
